// File: rtl/mem_copy_engine.sv
// mem_copy_engine
//
// Bus initiator that copies 16-bit words from a source region to a
// destination region over the byte-paired dual-port memory/IO interface.
// Port A carries the high byte at ptr, port B the low byte at ptr+1.
// Each word takes READ -> WAIT -> WRITE (3 cycles). Either pointer can
// be held fixed, so the IO input word (0xFFFE) can be streamed into RAM or
// RAM can be pushed to the output register (0xF010).
//
// Optional feature macro: MEMCOPY_FILL_EN
//   Adds inputs fill / fill_word. With fill=1 the engine writes fill_word
//   at the destination once per cycle (FILL_WRITE state) without reading.
//
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   start             one-cycle request, accepted only in IDLE
//   src_addr/dst_addr first source/destination byte address
//   len               word count (0 legal)
//   src_fixed/dst_fixed  hold the matching pointer constant
//   busy, done        status (busy: accept+1 .. DONE; done: DONE pulse)
//   m_addr_a/b, m_data_a/b, m_we_a/b  memory initiator outputs
//   m_q               read word {byte@addr_a, byte@addr_b}, 1-cycle latency
//   dbg_state         current FSM state encoding
//
// Handshake: start is a single-cycle strobe; it is taken only when the FSM
// is in IDLE and ignored otherwise. done is a single-cycle completion pulse.
module mem_copy_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   src_addr,
  input  logic [ADDR_WIDTH-1:0]   dst_addr,
  input  logic [15:0]             len,
  input  logic                    src_fixed,
  input  logic                    dst_fixed,
`ifdef MEMCOPY_FILL_EN
  input  logic                    fill,
  input  logic [15:0]             fill_word,
`endif
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   m_addr_a,
  output logic [ADDR_WIDTH-1:0]   m_addr_b,
  output logic [DATA_WIDTH-1:0]   m_data_a,
  output logic [DATA_WIDTH-1:0]   m_data_b,
  output logic                    m_we_a,
  output logic                    m_we_b,
  input  logic [2*DATA_WIDTH-1:0] m_q,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
`ifdef MEMCOPY_FILL_EN
    , S_FILL_WRITE
`endif
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] TWO = ADDR_WIDTH'(2);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   src_ptr;
  logic [ADDR_WIDTH-1:0]   dst_ptr;
  logic [15:0]             remaining;
  logic [2*DATA_WIDTH-1:0] data_reg;
  logic                    src_fixed_r;
  logic                    dst_fixed_r;
  logic [ADDR_WIDTH-1:0]   src_next;
  logic [ADDR_WIDTH-1:0]   dst_next;

  // Pointer arithmetic wraps naturally at 2^ADDR_WIDTH.
  assign src_next  = src_fixed_r ? src_ptr : src_ptr + TWO;
  assign dst_next  = dst_fixed_r ? dst_ptr : dst_ptr + TWO;
  assign dbg_state = state;

  // Write data is only driven while a write is on the bus; the bus is 0
  // otherwise so idle and read cycles present all-zero data.
  assign m_data_a = m_we_a ? data_reg[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
  assign m_data_b = m_we_b ? data_reg[DATA_WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      src_ptr     <= '0;
      dst_ptr     <= '0;
      remaining   <= '0;
      data_reg    <= '0;
      src_fixed_r <= 1'b0;
      dst_fixed_r <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      m_addr_a    <= '0;
      m_addr_b    <= '0;
      m_we_a      <= 1'b0;
      m_we_b      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            src_ptr     <= src_addr;
            dst_ptr     <= dst_addr;
            remaining   <= len;
            src_fixed_r <= src_fixed;
            dst_fixed_r <= dst_fixed;
            busy        <= 1'b1;
            if (len == 16'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
`ifdef MEMCOPY_FILL_EN
            else if (fill) begin
              // Fill writes start immediately; no read phase.
              state    <= S_FILL_WRITE;
              data_reg <= (2*DATA_WIDTH)'(fill_word);
              m_addr_a <= dst_addr;
              m_addr_b <= dst_addr + ONE;
              m_we_a   <= 1'b1;
              m_we_b   <= 1'b1;
            end
`endif
            else begin
              state    <= S_READ;
              m_addr_a <= src_addr;
              m_addr_b <= src_addr + ONE;
            end
          end
        end

        // Read address is already on the bus; hold it through WAIT.
        S_READ: state <= S_WAIT;

        S_WAIT: begin
          data_reg <= m_q;
          state    <= S_WRITE;
          m_addr_a <= dst_ptr;
          m_addr_b <= dst_ptr + ONE;
          m_we_a   <= 1'b1;
          m_we_b   <= 1'b1;
        end

        S_WRITE: begin
          src_ptr   <= src_next;
          dst_ptr   <= dst_next;
          remaining <= remaining - 16'd1;
          m_we_a    <= 1'b0;
          m_we_b    <= 1'b0;
          if (remaining == 16'd1) begin
            state    <= S_DONE;
            done     <= 1'b1;
            m_addr_a <= '0;
            m_addr_b <= '0;
          end else begin
            state    <= S_READ;
            m_addr_a <= src_next;
            m_addr_b <= src_next + ONE;
          end
        end

`ifdef MEMCOPY_FILL_EN
        S_FILL_WRITE: begin
          dst_ptr   <= dst_next;
          remaining <= remaining - 16'd1;
          if (remaining == 16'd1) begin
            state    <= S_DONE;
            done     <= 1'b1;
            m_addr_a <= '0;
            m_addr_b <= '0;
            m_we_a   <= 1'b0;
            m_we_b   <= 1'b0;
          end else begin
            m_addr_a <= dst_next;
            m_addr_b <= dst_next + ONE;
          end
        end
`endif

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Testbench for mem_copy_engine: a byte memory model with an optional IO
// overlay (input word at 0xFFFE, output register at 0xF010), directed copy
// scenarios, and a write monitor that pops expected bus writes from a queue.
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src_addr = '0;
  logic [15:0] dst_addr = '0;
  logic [15:0] len = '0;
  logic        src_fixed = 1'b0;
  logic        dst_fixed = 1'b0;
`ifdef MEMCOPY_FILL_EN
  logic        fill = 1'b0;
  logic [15:0] fill_word = '0;
`endif
  logic        busy, done;
  logic [15:0] m_addr_a, m_addr_b;
  logic [7:0]  m_data_a, m_data_b;
  logic        m_we_a, m_we_b;
  logic [15:0] m_q = '0;
  logic [2:0]  dbg_state;

  logic [7:0]  mem [0:65535];
  bit          io_en = 1'b0;
  logic [15:0] io_in = '0;
  logic [15:0] io_out;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [47:0] exp_q [$];

  mem_copy_engine dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .src_fixed(src_fixed), .dst_fixed(dst_fixed),
`ifdef MEMCOPY_FILL_EN
    .fill(fill), .fill_word(fill_word),
`endif
    .busy(busy), .done(done),
    .m_addr_a(m_addr_a), .m_addr_b(m_addr_b),
    .m_data_a(m_data_a), .m_data_b(m_data_b),
    .m_we_a(m_we_a), .m_we_b(m_we_b),
    .m_q(m_q), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory / IO model ----------------
  function automatic logic [7:0] rd(input logic [15:0] a);
    if (io_en && a == 16'hFFFE) return io_in[15:8];
    if (io_en && a == 16'hFFFF) return io_in[7:0];
    return mem[a];
  endfunction

  assign io_out = (io_en && m_we_a && m_addr_a == 16'hF010) ? {m_data_a, m_data_b} : 16'h0000;

  always @(posedge clk) begin
    if (m_we_a && !(io_en && m_addr_a == 16'hF010)) mem[m_addr_a] = m_data_a;
    if (m_we_b && !(io_en && m_addr_b == 16'hF011)) mem[m_addr_b] = m_data_b;
    m_q <= {rd(m_addr_a), rd(m_addr_b)};
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (m_we_a || m_we_b) begin
      check("we_pair", m_we_b, m_we_a);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {m_addr_a, m_addr_b, m_data_a, m_data_b}, 48'h0);
      end else begin
        check("write_bus", {m_addr_a, m_addr_b, m_data_a, m_data_b}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  int last_we_n;

  task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                          input logic sf, input logic df, input int exp_cycles, input bit poke);
    int  k, busy_n, we_n;
    bit  got;
    @(negedge clk);
    src_addr = s; dst_addr = d; len = l; src_fixed = sf; dst_fixed = df; start = 1'b1;
    @(posedge clk);          // accept edge N
    @(negedge clk);          // cycle N+1
    k = 1; busy_n = 0; we_n = 0; got = 1'b0;
    while (k <= 300) begin
      // Optional ignored start while busy, with different parameters.
      start = (poke && k == 4);
      if (poke && k == 4) begin
        src_addr = 16'h7770; dst_addr = 16'h7780; len = 16'd9;
      end
      if (busy) busy_n++;
      if (m_we_a || m_we_b) we_n++;
      if (done) begin got = 1'b1; break; end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check("done_seen", got, 1);
    check("done_cycle", k, exp_cycles);
    check("busy_cycles", busy_n, exp_cycles);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    last_we_n = we_n;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", {m_addr_a, m_addr_b}, 32'h0);
    check("rst_data", {m_data_a, m_data_b}, 16'h0);
    check("rst_we", {m_we_a, m_we_b}, 2'b00);
    reset = 1'b1;
    @(negedge clk);

    // Basic copy of 3 words, with an ignored start mid-run
    mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22; mem[16'h0102] = 8'h33;
    mem[16'h0103] = 8'h44; mem[16'h0104] = 8'h55; mem[16'h0105] = 8'h66;
    exp_q.push_back({16'h0200, 16'h0201, 16'h1122});
    exp_q.push_back({16'h0202, 16'h0203, 16'h3344});
    exp_q.push_back({16'h0204, 16'h0205, 16'h5566});
    run_copy(16'h0100, 16'h0200, 16'd3, 1'b0, 1'b0, 10, 1'b1);
    check("copy_mem", {mem[16'h0200], mem[16'h0201], mem[16'h0202], mem[16'h0203],
                       mem[16'h0204], mem[16'h0205]}, 48'h112233445566);
    check("copy_no_extra", {mem[16'h7780], mem[16'h0206]}, 16'h0);

    // len = 0: done next cycle, no writes
    run_copy(16'h0100, 16'h0900, 16'd0, 1'b0, 1'b0, 1, 1'b0);
    check("len0_no_we", last_we_n, 0);

    // Source wrap at 0xFFFE
    mem[16'hFFFE] = 8'hAB; mem[16'hFFFF] = 8'hCD; mem[16'h0000] = 8'hEF; mem[16'h0001] = 8'h01;
    exp_q.push_back({16'h0300, 16'h0301, 16'hABCD});
    exp_q.push_back({16'h0302, 16'h0303, 16'hEF01});
    run_copy(16'hFFFE, 16'h0300, 16'd2, 1'b0, 1'b0, 7, 1'b0);
    check("wrap_mem", {mem[16'h0300], mem[16'h0301], mem[16'h0302], mem[16'h0303]}, 32'hABCDEF01);

    // Destination at 0xFFFF: port B wraps to 0x0000; odd source address
    exp_q.push_back({16'hFFFF, 16'h0000, 16'h2233});
    run_copy(16'h0101, 16'hFFFF, 16'd1, 1'b0, 1'b0, 4, 1'b0);
    check("dst_wrap_mem", {mem[16'hFFFF], mem[16'h0000]}, 16'h2233);

    // Stream IO input word to IO output register, both pointers fixed
    io_en = 1'b1; io_in = 16'h1234;
    exp_q.push_back({16'hF010, 16'hF011, 16'h1234});
    exp_q.push_back({16'hF010, 16'hF011, 16'h1234});
    run_copy(16'hFFFE, 16'hF010, 16'd2, 1'b1, 1'b1, 7, 1'b0);
    check("io_out_idle", io_out, 16'h0);
    check("io_ram_untouched", {mem[16'hF010], mem[16'hF011]}, 16'h0);
    io_en = 1'b0;

    // Reset in the second WAIT cycle of a 4-word copy
    for (int i = 0; i < 8; i++) mem[16'h0500 + i] = 8'hA1 + 8'(i);
    exp_q.push_back({16'h0600, 16'h0601, 16'hA1A2});
    @(negedge clk);
    src_addr = 16'h0500; dst_addr = 16'h0600; len = 16'd4;
    src_fixed = 1'b0; dst_fixed = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);   // now in cycle N+5 (second WAIT)
    check("pre_rst_busy", busy, 1);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_bus", {m_addr_a, m_addr_b, m_data_a, m_data_b, m_we_a, m_we_b}, 50'h0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_first_word", {mem[16'h0600], mem[16'h0601]}, 16'hA1A2);
    check("midrst_second_word", {mem[16'h0602], mem[16'h0603]}, 16'h0);
    exp_q.push_back({16'h0610, 16'h0611, 16'hA7A8});
    run_copy(16'h0506, 16'h0610, 16'd1, 1'b0, 1'b0, 4, 1'b0);
    check("post_rst_mem", {mem[16'h0610], mem[16'h0611]}, 16'hA7A8);

`ifdef MEMCOPY_FILL_EN
    // Fill mode: one word per cycle
    fill = 1'b1; fill_word = 16'hBEEF;
    for (int i = 0; i < 4; i++) exp_q.push_back({16'h0400 + 16'(2*i), 16'h0401 + 16'(2*i), 16'hBEEF});
    run_copy(16'h0000, 16'h0400, 16'd4, 1'b0, 1'b0, 5, 1'b0);
    fill = 1'b0;
    check("fill_mem", {mem[16'h0400], mem[16'h0401], mem[16'h0406], mem[16'h0407]}, 32'hBEEFBEEF);
    check("fill_end", mem[16'h0408], 0);
`endif

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
